// File: rtl/tlb_pkg.sv
// rtl/tlb_pkg.sv - Shared TLB constants, entry layout and enums
// Purpose: common definitions for the TLB table and the lookup path.
// Contents: entry count, entry field offsets, 71-bit entry type, CP0 TLB op codes, table FSM states.
package tlb_pkg;

    localparam int TLB_ENTRIES = 16;
    localparam int TLB_IDX_W   = 4;
    localparam int TLB_ENTRY_W = 71;

    localparam int VPN2_HI = 70;
    localparam int VPN2_LO = 52;
    localparam int PFN1_HI = 51;
    localparam int PFN1_LO = 28;
    localparam int D1      = 27;
    localparam int V1      = 26;
    localparam int PFN0_HI = 25;
    localparam int PFN0_LO = 2;
    localparam int D0      = 1;
    localparam int V0      = 0;

    typedef logic [TLB_ENTRY_W-1:0] tlb_entry_t;

    typedef enum logic [1:0] {
        TLBR  = 2'b00,
        TLBWI = 2'b01,
        TLBWR = 2'b10,
        TLBP  = 2'b11
    } tlb_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } tlb_state_e;

endpackage

// File: rtl/tlb_random_counter.sv
// rtl/tlb_random_counter.sv - CP0 Random register, wraps above Wired
// Purpose: free-running down counter used as the TLBWR replacement index.
// Ports: clk, rst_n (sync, active-low), wired_i (CP0 Wired), wired_we (Wired write strobe),
//        random_o (current Random value, 15 after reset).
module tlb_random_counter
    import tlb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [TLB_IDX_W-1:0] wired_i,
    input  logic                 wired_we,
    output logic [TLB_IDX_W-1:0] random_o
);

    logic [TLB_IDX_W-1:0] r_random;

    // Reloading whenever Random is at or below Wired keeps the wired entries
    // out of the replacement range, and pins Random at 15 when Wired is 15.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_random <= '1;
        end else if (wired_we || (r_random <= wired_i)) begin
            r_random <= '1;
        end else begin
            r_random <= r_random - 4'd1;
        end
    end

    assign random_o = r_random;

endmodule

// File: rtl/tlb_table.sv
// rtl/tlb_table.sv - 16-entry TLB entry store with TLBR/TLBWI/TLBWR/TLBP engine
// Purpose: holds the TLB entries for the lookup path and executes CP0 TLB ops.
// Ports: clk, rst_n (sync, active-low); op_valid/op_ready/op request handshake;
//        index_i, entry_i, wired_i, wired_we inputs; done, rd_entry, probe_index,
//        probe_miss registered results; random_o; entries (packed, entry i at [71*i +: 71]).
module tlb_table
    import tlb_pkg::*;
#(
    parameter int N_ENTRIES = TLB_ENTRIES
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             op_valid,
    output logic                             op_ready,
    input  logic [1:0]                       op,
    input  logic [TLB_IDX_W-1:0]             index_i,
    input  logic [TLB_ENTRY_W-1:0]           entry_i,
    input  logic [TLB_IDX_W-1:0]             wired_i,
    input  logic                             wired_we,
    output logic                             done,
    output logic [TLB_ENTRY_W-1:0]           rd_entry,
    output logic [TLB_IDX_W-1:0]             probe_index,
    output logic                             probe_miss,
    output logic [TLB_IDX_W-1:0]             random_o,
    output logic [TLB_ENTRY_W*N_ENTRIES-1:0] entries
);

    tlb_state_e           r_state, w_state_n;
    tlb_entry_t           r_entries [TLB_ENTRIES];
    logic [TLB_IDX_W-1:0] r_j, w_j_n;
    logic [18:0]          r_vpn, w_vpn_n;
    logic                 r_done, w_done_n;
    tlb_entry_t           r_rd, w_rd_n;
    logic [TLB_IDX_W-1:0] r_pidx, w_pidx_n;
    logic                 r_pmiss, w_pmiss_n;
    logic                 w_we;
    logic [TLB_IDX_W-1:0] w_waddr;
    logic [TLB_IDX_W-1:0] w_random;

    tlb_random_counter u_random (
        .clk      (clk),
        .rst_n    (rst_n),
        .wired_i  (wired_i),
        .wired_we (wired_we),
        .random_o (w_random)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_j     <= '0;
            r_vpn   <= '0;
            r_done  <= 1'b0;
            r_rd    <= '0;
            r_pidx  <= '0;
            r_pmiss <= 1'b0;
            for (int i = 0; i < TLB_ENTRIES; i++) begin
                r_entries[i] <= '0;
            end
        end else begin
            r_state <= w_state_n;
            r_j     <= w_j_n;
            r_vpn   <= w_vpn_n;
            r_done  <= w_done_n;
            r_rd    <= w_rd_n;
            r_pidx  <= w_pidx_n;
            r_pmiss <= w_pmiss_n;
            if (w_we) begin
                r_entries[w_waddr] <= entry_i;
            end
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_j_n     = r_j;
        w_vpn_n   = r_vpn;
        w_done_n  = 1'b0;
        w_rd_n    = r_rd;
        w_pidx_n  = r_pidx;
        w_pmiss_n = r_pmiss;
        w_we      = 1'b0;
        w_waddr   = index_i;
        case (r_state)
            ST_IDLE: begin
                if (op_valid) begin
                    case (tlb_op_e'(op))
                        TLBR: begin
                            w_rd_n   = r_entries[index_i];
                            w_done_n = 1'b1;
                        end
                        TLBWI: begin
                            w_we     = 1'b1;
                            w_done_n = 1'b1;
                        end
                        TLBWR: begin
                            w_we     = 1'b1;
                            w_waddr  = w_random;
                            w_done_n = 1'b1;
                        end
                        default: begin
                            w_vpn_n   = entry_i[VPN2_HI:VPN2_LO];
                            w_j_n     = '0;
                            w_state_n = ST_SCAN;
                        end
                    endcase
                end
            end
            default: begin
                // One comparator walked across the array; the first match ends
                // the scan so the lowest matching index is reported.
                if (r_entries[r_j][VPN2_HI:VPN2_LO] == r_vpn) begin
                    w_pidx_n  = r_j;
                    w_pmiss_n = 1'b0;
                    w_done_n  = 1'b1;
                    w_state_n = ST_IDLE;
                end else if (r_j == 4'(TLB_ENTRIES - 1)) begin
                    w_pidx_n  = '0;
                    w_pmiss_n = 1'b1;
                    w_done_n  = 1'b1;
                    w_state_n = ST_IDLE;
                end else begin
                    w_j_n = r_j + 4'd1;
                end
            end
        endcase
    end

    genvar g;
    generate
        for (g = 0; g < N_ENTRIES; g++) begin : g_entries
            assign entries[TLB_ENTRY_W*g +: TLB_ENTRY_W] = r_entries[g];
        end
    endgenerate

    assign op_ready    = (r_state == ST_IDLE);
    assign done        = r_done;
    assign rd_entry    = r_rd;
    assign probe_index = r_pidx;
    assign probe_miss  = r_pmiss;
    assign random_o    = w_random;

endmodule

// File: tb/tb_tlb_table.sv
// tb/tb_tlb_table.sv - Directed table-driven bench for tlb_table
module tb_tlb_table;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          op_valid;
    logic          op_ready;
    logic [1:0]    op;
    logic [3:0]    index_i;
    logic [70:0]   entry_i;
    logic [3:0]    wired_i;
    logic          wired_we;
    logic          done;
    logic [70:0]   rd_entry;
    logic [3:0]    probe_index;
    logic          probe_miss;
    logic [3:0]    random_o;
    logic [71*16-1:0] entries;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  idx;
        logic [70:0] ent;
        logic [70:0] exp_rd;
    } vec_t;

    vec_t tbl [10];

    tlb_table dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op          (op),
        .index_i     (index_i),
        .entry_i     (entry_i),
        .wired_i     (wired_i),
        .wired_we    (wired_we),
        .done        (done),
        .rd_entry    (rd_entry),
        .probe_index (probe_index),
        .probe_miss  (probe_miss),
        .random_o    (random_o),
        .entries     (entries)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [70:0] act, input logic [70:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [70:0] ent_at(input int i);
        return entries[71*i +: 71];
    endfunction

    function automatic logic [70:0] mk(input logic [18:0] vpn, input logic [23:0] pfn1,
                                       input logic [23:0] pfn0, input logic [3:0] flags);
        return {vpn, pfn1, flags[3], flags[2], pfn0, flags[1], flags[0]};
    endfunction

    // Issues a TLBP for vpn, measures acceptance-to-done latency and checks results.
    task automatic probe(input logic [18:0] vpn, input int exp_lat, input logic [3:0] exp_idx,
                         input logic exp_miss, input logic hold);
        int cnt;
        op       = 2'b11;
        entry_i  = {vpn, 52'h0};
        op_valid = 1'b1;
        tick();
        if (!hold) op_valid = 1'b0;
        cnt = 1;
        while (done !== 1'b1 && cnt < 40) begin
            chk("probe_ready_low", {70'h0, op_ready}, 71'd0);
            tick();
            cnt++;
        end
        chk("probe_latency", 71'(cnt), 71'(exp_lat));
        chk("probe_index", {67'h0, probe_index}, {67'h0, exp_idx});
        chk("probe_miss", {70'h0, probe_miss}, {70'h0, exp_miss});
        chk("probe_ready_at_done", {70'h0, op_ready}, 71'd1);
    endtask

    logic [70:0] e_w7;
    int exp_rand;

    initial begin
        rst_n    = 1'b0;
        op_valid = 1'b0;
        op       = 2'b00;
        index_i  = 4'd0;
        entry_i  = '0;
        wired_i  = 4'd15;
        wired_we = 1'b0;

        tbl[0] = '{2'b01, 4'd3, mk(19'h12345, 24'h0, 24'h0, 4'b0001), 71'h0};
        tbl[1] = '{2'b00, 4'd3, 71'h0, mk(19'h12345, 24'h0, 24'h0, 4'b0001)};
        tbl[2] = '{2'b01, 4'd0, mk(19'h00111, 24'hA5A5A5, 24'h5A5A5A, 4'b1101), 71'h0};
        tbl[3] = '{2'b01, 4'd1, mk(19'h7FFFF, 24'hFFFFFF, 24'h000001, 4'b0110), 71'h0};
        tbl[4] = '{2'b00, 4'd0, 71'h0, mk(19'h00111, 24'hA5A5A5, 24'h5A5A5A, 4'b1101)};
        tbl[5] = '{2'b00, 4'd1, 71'h0, mk(19'h7FFFF, 24'hFFFFFF, 24'h000001, 4'b0110)};
        tbl[6] = '{2'b00, 4'd2, 71'h0, 71'h0};
        tbl[7] = '{2'b01, 4'd5, mk(19'h00ABC, 24'h000055, 24'h000066, 4'b0000), 71'h0};
        tbl[8] = '{2'b01, 4'd9, mk(19'h00ABC, 24'h000099, 24'h000088, 4'b1111), 71'h0};
        tbl[9] = '{2'b00, 4'd9, 71'h0, mk(19'h00ABC, 24'h000099, 24'h000088, 4'b1111)};

        e_w7 = mk(19'h07777, 24'h123456, 24'h654321, 4'b1010);

        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_random", {67'h0, random_o}, 71'd15);
        chk("rst_ready", {70'h0, op_ready}, 71'd1);
        chk("rst_done", {70'h0, done}, 71'd0);
        chk("rst_rd_entry", rd_entry, 71'd0);
        chk("rst_probe_index", {67'h0, probe_index}, 71'd0);
        chk("rst_probe_miss", {70'h0, probe_miss}, 71'd0);
        chk("rst_entries_zero", {70'h0, entries == '0}, 71'd1);

        // Back-to-back requests: op_valid stays high across the whole table.
        for (int i = 0; i < 10; i++) begin
            op       = tbl[i].op;
            index_i  = tbl[i].idx;
            entry_i  = tbl[i].ent;
            op_valid = 1'b1;
            tick();
            chk("vec_done", {70'h0, done}, 71'd1);
            chk("vec_ready", {70'h0, op_ready}, 71'd1);
            if (tbl[i].op == 2'b00) chk("vec_rd_entry", rd_entry, tbl[i].exp_rd);
            else chk("vec_entry_written", ent_at(int'(tbl[i].idx)), tbl[i].ent);
        end
        op_valid = 1'b0;
        tick();
        chk("done_single_pulse", {70'h0, done}, 71'd0);
        chk("entry3_kept", ent_at(3), mk(19'h12345, 24'h0, 24'h0, 4'b0001));

        probe(19'h00ABC, 7, 4'd5, 1'b0, 1'b0);
        tick();
        chk("probe_done_pulse", {70'h0, done}, 71'd0);
        probe(19'h12345, 5, 4'd3, 1'b0, 1'b0);
        tick();

        // Random sweep with Wired = 4.
        wired_i  = 4'd4;
        exp_rand = 15;
        chk("rand_start", {67'h0, random_o}, 71'd15);
        for (int k = 0; k < 12; k++) begin
            tick();
            exp_rand = (exp_rand <= 4) ? 15 : exp_rand - 1;
            chk("rand_seq", {67'h0, random_o}, 71'(exp_rand));
        end
        chk("rand_wrapped", {67'h0, random_o}, 71'd15);
        while (exp_rand != 9) begin
            tick();
            exp_rand = exp_rand - 1;
        end
        chk("rand_at9", {67'h0, random_o}, 71'd9);
        wired_we = 1'b1;
        tick();
        wired_we = 1'b0;
        chk("rand_wired_we", {67'h0, random_o}, 71'd15);
        exp_rand = 15;
        while (exp_rand != 7) begin
            tick();
            exp_rand = exp_rand - 1;
        end
        chk("rand_at7", {67'h0, random_o}, 71'd7);
        op       = 2'b10;
        index_i  = 4'd0;
        entry_i  = e_w7;
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        chk("tlbwr_done", {70'h0, done}, 71'd1);
        chk("tlbwr_entry7", ent_at(7), e_w7);
        chk("tlbwr_entry0_kept", ent_at(0), mk(19'h00111, 24'hA5A5A5, 24'h5A5A5A, 4'b1101));
        wired_i = 4'd15;
        tick();
        chk("rand_wired15", {67'h0, random_o}, 71'd15);

        // Miss with op_valid held: re-accepted only in the done cycle.
        probe(19'h55555, 17, 4'd0, 1'b1, 1'b1);
        tick();
        op_valid = 1'b0;
        chk("reaccept_no_done", {70'h0, done}, 71'd0);
        chk("reaccept_busy", {70'h0, op_ready}, 71'd0);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        chk("midscan_rst_done", {70'h0, done}, 71'd0);
        tick();
        rst_n = 1'b1;
        chk("midscan_rst_done2", {70'h0, done}, 71'd0);
        chk("midscan_rst_ready", {70'h0, op_ready}, 71'd1);
        chk("midscan_rst_random", {67'h0, random_o}, 71'd15);
        chk("midscan_rst_entries", {70'h0, entries == '0}, 71'd1);
        tick();
        chk("post_rst_done", {70'h0, done}, 71'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tlb_table.md
# tlb_table

Storage and maintenance engine for the 16-entry joint MIPS TLB. It holds the entry array that the combinational TLB lookup path reads, and executes CP0 TLB instructions (TLBR, TLBWI, TLBWR, TLBP) issued by the execute/CP0 stage over a valid/ready handshake. It also maintains the Random register against Wired. Probe is a sequential scan, one entry per cycle, to keep comparator area off the critical lookup path.

## Interface
- `N_ENTRIES`, 16: entry count; the index width is fixed at 4.
- `clk  in  1`: clock.
- `rst_n  in  1`: reset, synchronous, active-low.
- `op_valid  in  1`: request valid.
- `op_ready  out  1`: block can accept a request; high only in IDLE.
- `op  in  2`: 00 TLBR, 01 TLBWI, 10 TLBWR, 11 TLBP.
- `index_i  in  4`: CP0 Index, used by TLBR and TLBWI.
- `entry_i  in  71`: composed EntryHi/EntryLo0/EntryLo1 for writes. Bits [70:52] also carry the probe VPN2.
- `wired_i  in  4`: CP0 Wired value.
- `wired_we  in  1`: Wired is being written this cycle.
- `done  out  1`: one-cycle completion pulse.
- `rd_entry  out  71`: TLBR result, valid at `done`.
- `probe_index  out  4`: TLBP hit index, valid at `done`.
- `probe_miss  out  1`: TLBP found no match, valid at `done`.
- `random_o  out  4`: current Random value.
- `entries  out  16×71 packed`: entry i at bits [71*i+70 : 71*i], feeding the lookup path.

Entry format:
- [70:52] VPN2
- [51:28] PFN1
- [27] D1
- [26] V1
- [25:2] PFN0
- [1] D0
- [0] V0

## Operation
FSM states: IDLE, SCAN.

A request is accepted when `op_valid && op_ready`.

- **TLBR:** `rd_entry <= entries[index_i]`; `done` next cycle; FSM stays in IDLE.
- **TLBWI:** `entries[index_i] <= entry_i`.
- **TLBWR:** `entries[random_o] <= entry_i`, using the Random value in the acceptance cycle.
- **TLBP:**
  - Latch `entry_i[70:52]` and go to SCAN with scan pointer j = 0.
  - In SCAN, compare entries[j].VPN2 to the latched VPN2. The valid bits are ignored.
  - On the first match: `probe_index <= j`, `probe_miss <= 0`, return to IDLE.
  - On j == 15 with no match: `probe_miss <= 1`, `probe_index <= 0`, return to IDLE.
  - Otherwise j++.
  - Lowest matching index wins.

Random counter:
- Updates every cycle, independent of requests.
- `wired_we` sets it to 15; this has priority over decrementing.
- Otherwise, if `random_o <= wired_i`, it becomes 15; else it decrements by 1.
- With `wired_i` = 15, it stays at 15.

Reset values:
- Every entry is 0.
- `random_o` = 15.
- `done`, `rd_entry`, `probe_index`, `probe_miss` are 0.
- FSM is in IDLE; `op_ready` = 1.

Reset asserted mid-SCAN aborts the probe with no `done`; reset values apply on the next cycle. Requests while `op_ready` = 0 are ignored, and the issuer holds `op_valid`.

## Timing
- Request accepted in cycle N.
- TLBR/TLBWI/TLBWR: `done` at N+1. A written entry is visible on `entries` at N+1, and `op_ready` is high at N+1, so back-to-back ops are allowed.
- TLBP hit at index k: `done` at N+2+k.
- TLBP miss: `done` at N+17.
- `op_ready` is low from N+1 until the `done` cycle. It is high in the `done` cycle, so a new request can be accepted there.
- `done`, `rd_entry`, `probe_*` are registered outputs.
- `entries` is a direct register output with no bypass. A TLBR in the cycle after a write to the same index returns the new value.

## Structure
- `tlb_pkg` holds:
  - `TLB_ENTRIES` = 16
  - entry field offset constants (VPN2_HI/LO, PFN1, D1, V1, PFN0, D0, V0)
  - a `tlb_entry_t` 71-bit typedef
  - `tlb_op_e` {TLBR, TLBWI, TLBWR, TLBP}
  - the FSM state enum
- `tlb_pkg` is shared with the lookup path.
- One sub-module, `tlb_random_counter` (clk, rst_n, wired_i, wired_we → random_o), is instantiated inside.

## Test plan
- **Reset, then TLBWI:** after reset, `random_o` = 15 and all entries are 0. TLBWI index 3, entry VPN2 = 0x12345, V0 = 1 → `entries[3]` updated and `done` at N+1. A following TLBR index 3 returns the same 71-bit value.
- **TLBP hit, lowest index:** write VPN2 0x00ABC into entries 5 and 9, then TLBP 0x00ABC → `probe_index` = 5, `probe_miss` = 0, `done` exactly 7 cycles after acceptance.
- **TLBP miss:** TLBP on an unused VPN2 → `probe_miss` = 1, `done` at N+17. `op_valid` held during SCAN is not accepted until the `done` cycle.
- **Random wrap and Wired write:** with `wired_i` = 4, Random cycles 15, 14, …, 4, 15. Pulsing `wired_we` when Random = 9 gives 15 the next cycle. TLBWR at Random = 7 writes entry 7.
- **Reset mid-probe:** drop `rst_n` during SCAN → no `done`; all entries 0, `op_ready` = 1, `random_o` = 15 after reset.
- **Back-to-back writes:** TLBWI idx 0 then idx 1 in consecutive cycles → both accepted, two `done` pulses at N+1 and N+2, and both entries correct.
